// File: rtl/fetch_unit.sv
// fetch_unit: fetch/decode sequencer sitting behind the program counter.
// Owns the 16x8 program store, MAR/MDR/IR and the PC increment/load requests.
module fetch_unit #(
   parameter int         ADDR_W  = 4,
   parameter int         DATA_W  = 8,
   parameter logic [3:0] JMP_OPC = 4'h6,
   parameter logic [3:0] HLT_OPC = 4'hF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] PC_IN,
   output logic              PC_INC,
   output logic              PC_LD,
   output logic [ADDR_W-1:0] PC_LD_VAL,
   input  logic              PROG_WE,
   input  logic [ADDR_W-1:0] PROG_ADDR,
   input  logic [DATA_W-1:0] PROG_DATA,
   input  logic              EXEC_DONE,
   output logic [3:0]        OPCODE,
   output logic [3:0]        OPERAND,
   output logic              IR_VALID,
   output logic              HALTED,
   output logic [2:0]        STATE
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_READ   = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] mar_q;
   logic [DATA_W-1:0] mdr_q;
   logic [DATA_W-1:0] ir_q;
   logic              ir_valid_q;
   logic              halted_q;
   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   logic [3:0]        mdr_opc;

   assign mdr_opc = mdr_q[DATA_W-1 -: 4];

   // PC requests come straight from DECODE and the word just fetched
   always_comb begin
      PC_INC    = 1'b0;
      PC_LD     = 1'b0;
      PC_LD_VAL = '0;
      if (state_q == S_DECODE) begin
         if (mdr_opc == JMP_OPC) begin
            PC_LD     = 1'b1;
            PC_LD_VAL = mdr_q[ADDR_W-1:0];
         end else if (mdr_opc != HLT_OPC) begin
            PC_INC = 1'b1;
         end
      end
   end

   // Program store write port; contents survive reset, writes blocked in it
   always_ff @(posedge CLK) begin
      if (!RST && PROG_WE) begin
         mem_q[PROG_ADDR] <= PROG_DATA;
      end
   end

   // Fetch/decode sequencer with registered status flags
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_FETCH;
         mar_q      <= '0;
         mdr_q      <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               mar_q   <= PC_IN;
               state_q <= S_READ;
            end
            S_READ: begin
               mdr_q   <= mem_q[mar_q];
               state_q <= S_DECODE;
            end
            S_DECODE: begin
               ir_q <= mdr_q;
               if (mdr_opc == HLT_OPC) begin
                  state_q  <= S_HALT;
                  halted_q <= 1'b1;
               end else if (mdr_opc == JMP_OPC) begin
                  state_q <= S_FETCH;
               end else begin
                  state_q    <= S_EXEC;
                  ir_valid_q <= 1'b1;
               end
            end
            S_EXEC: begin
               if (EXEC_DONE) begin
                  state_q    <= S_FETCH;
                  ir_valid_q <= 1'b0;
               end
            end
            S_HALT: begin
               state_q <= S_HALT;
            end
            default: begin
               state_q    <= S_FETCH;
               ir_valid_q <= 1'b0;
               halted_q   <= 1'b0;
            end
         endcase
      end
   end

   assign OPCODE   = ir_q[DATA_W-1 -: 4];
   assign OPERAND  = ir_q[3:0];
   assign IR_VALID = ir_valid_q;
   assign HALTED   = halted_q;
   assign STATE    = state_q;

endmodule
